vc_fifo: RTL and testbench

VC_FIFO -- requirements
Module: vc_fifo

---
 rtl/vc_fifo_pkg.sv | 23 ++
 rtl/vc_fifo_if.sv | 32 +++
 rtl/vc_fifo_mem.sv | 28 ++
 rtl/vc_fifo.sv | 85 ++++++++
 tb/tb_vc_fifo.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/vc_fifo_pkg.sv
// Shared project constants for the virtual-channel FIFOs and the mux they feed.
// Also holds the operation encoding used by the FIFO control logic.
package vc_fifo_pkg;

    localparam int BITNUMBER_DEF = 5;
    localparam int DEPTH_DEF     = 8;
    localparam int AF_THRESH_DEF = 6;
    localparam int AE_THRESH_DEF = 2;
    localparam int PTR_W_DEF     = $clog2(DEPTH_DEF);

    // Bit 0 is the push and bit 1 is the pop, so the value is {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic do_push, input logic do_pop);
        return fifo_op_e'({do_pop, do_push});
    endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Handshake and status bundle of one virtual-channel FIFO.
// The producer/consumer side uses master and the FIFO uses slave.
interface vc_fifo_if
    import vc_fifo_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int DEPTH     = DEPTH_DEF
) ();

    logic                     push;
    logic [BITNUMBER-1:0]     data_in;
    logic                     pop;
    logic [BITNUMBER-1:0]     data_out;
    logic                     valid_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic                     error;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, error, fifo_count
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, error, fifo_count
    );

endinterface

// File: rtl/vc_fifo_mem.sv
// DEPTH x BITNUMBER storage array: registered write, asynchronous read.
// Contents are deliberately left uninitialised by reset.
module fifo_mem
    import vc_fifo_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  logic [BITNUMBER-1:0] wdata,
    input  logic [PTR_W-1:0]     raddr,
    output logic [BITNUMBER-1:0] rdata
);

    logic [BITNUMBER-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vc_fifo.sv
// Virtual-channel FIFO control: pointers, occupancy, sticky error and the
// registered read port that feeds the mux data/valid inputs.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    vc_fifo_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [BITNUMBER-1:0] rd_data;
    logic                 do_push;
    logic                 do_pop;
    logic                 err_now;
    fifo_op_e             op;

    // A pop on a full FIFO frees a slot on the same edge, so a simultaneous push is accepted.
    always_comb begin
        do_pop  = bus.pop && !bus.empty;
        do_push = bus.push && (!bus.full || do_pop);
        err_now = (bus.push && bus.full && !bus.pop) || (bus.pop && bus.empty);
        op      = decode_op(do_push, do_pop);
    end

    fifo_mem #(
        .BITNUMBER (BITNUMBER),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            bus.valid_out <= do_pop;
            if (do_pop) begin
                bus.data_out <= rd_data;
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (err_now) begin
                bus.error <= 1'b1;
            end
            case (op)
                OP_PUSH: count <= count + CNT_W'(1);
                OP_POP:  count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        bus.fifo_count   = count;
        bus.full         = (count == CNT_W'(DEPTH));
        bus.empty        = (count == '0);
        bus.almost_full  = (count >= CNT_W'(AF_THRESH));
        bus.almost_empty = (count <= CNT_W'(AE_THRESH));
    end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo: a vector table for the basic flow and underflow,
// plus hand-written sequences for fill/overflow, full push+pop, wrap and async reset.
module tb_vc_fifo;
    import vc_fifo_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    vc_fifo_if #(.BITNUMBER(5), .DEPTH(8)) bus ();

    vc_fifo #(
        .BITNUMBER (5),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       push;
        logic [4:0] din;
        logic       pop;
        logic [4:0] expData;
        logic       expValid;
        int         expCount;
        logic       expErr;
    } vec_t;

    vec_t vecs [11];
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic [4:0] modelQ [$];
    logic [4:0] expWord;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Flag expectations come from the occupancy with DEPTH=8, AF=6, AE=2.
    task automatic checkAll(input string tag, input logic [4:0] d, input logic v, input int c, input logic e);
        checkOutput({tag, " data_out"},     32'(bus.data_out),     32'(d));
        checkOutput({tag, " valid_out"},    32'(bus.valid_out),    32'(v));
        checkOutput({tag, " fifo_count"},   32'(bus.fifo_count),   32'(c));
        checkOutput({tag, " error"},        32'(bus.error),        32'(e));
        checkOutput({tag, " full"},         32'(bus.full),         32'(c == 8));
        checkOutput({tag, " empty"},        32'(bus.empty),        32'(c == 0));
        checkOutput({tag, " almost_full"},  32'(bus.almost_full),  32'(c >= 6));
        checkOutput({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(c <= 2));
    endtask

    task automatic applyStimulus(input logic p, input logic [4:0] d, input logic q);
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic doReset();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        reset       = 1'b0;
        repeat (2) @(negedge clk);
        checkAll("reset", 5'd0, 1'b0, 0, 1'b0);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic p, input logic [4:0] d, input logic q,
                                input logic [4:0] ed, input logic ev, input int ec, input logic ee);
        vec_t r;
        r.push = p; r.din = d; r.pop = q;
        r.expData = ed; r.expValid = ev; r.expCount = ec; r.expErr = ee;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1, 1'b0);
        vecs[1]  = mk(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 2, 1'b0);
        vecs[2]  = mk(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 3, 1'b0);
        vecs[3]  = mk(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 4, 1'b0);
        vecs[4]  = mk(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 3, 1'b0);
        vecs[5]  = mk(1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 2, 1'b0);
        vecs[6]  = mk(1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 1, 1'b0);
        vecs[7]  = mk(1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 0, 1'b0);
        vecs[8]  = mk(1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 0, 1'b0);
        vecs[9]  = mk(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1, 1'b1);
        vecs[10] = mk(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 0, 1'b1);

        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].push, vecs[i].din, vecs[i].pop);
            checkAll($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expValid,
                     vecs[i].expCount, vecs[i].expErr);
        end

        // Fill to full, overflow once, then drain: the dropped word must not appear.
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b0);
            checkAll($sformatf("fill%0d", i), 5'd0, 1'b0, i, 1'b0);
        end
        applyStimulus(1'b1, 5'd9, 1'b0);
        checkAll("overflow", 5'd0, 1'b0, 8, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1);
            checkAll($sformatf("drain%0d", i), 5'(i), 1'b1, 8 - i, 1'b1);
        end

        // Push and pop together while full: both happen, no error.
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b0);
        end
        applyStimulus(1'b1, 5'd9, 1'b1);
        checkAll("fullboth", 5'd1, 1'b1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1);
            checkAll($sformatf("fdrain%0d", i), 5'(i + 2), 1'b1, 7 - i, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 1'b0);
        checkAll("fidle", 5'd9, 1'b0, 0, 1'b0);

        // Steady push/pop pairs at occupancy 3, wrapping the pointers several times.
        doReset();
        modelQ.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 1'b0);
            modelQ.push_back(5'(20 + i));
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 5'(k), 1'b1);
            expWord = modelQ.pop_front();
            modelQ.push_back(5'(k));
            checkAll($sformatf("wrap%0d", k), expWord, 1'b1, 3, 1'b0);
        end

        // Asynchronous reset mid-stream with error set and a word just popped.
        doReset();
        applyStimulus(1'b0, 5'd0, 1'b1);
        checkAll("preunder", 5'd0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(11 + i), 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 1'b1);
        checkAll("prereset", 5'd11, 1'b1, 5, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkAll("asyncreset", 5'd0, 1'b0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1);
        checkAll("postreset", 5'd0, 1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
